// File: rtl/fp32_mac_accumulator_if.sv
// Product stream in / accumulated result out for fp32_mac_accumulator.
// master = producer/consumer side, slave = the accumulator.
interface fp32_mac_accumulator_if #(
   parameter int XLEN    = 32,
   parameter int MAX_LEN = 256
) ();
   localparam int CNT_W = $clog2(MAX_LEN + 1);

   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/fp32_mac_accumulator.sv
// FP32 running-sum accumulator (FTZ, truncating, saturate to inf), one result per vector.
// Optional macro ACC_RELU_EN clamps negative results to +0 on out_data.
module fp32_mac_accumulator #(
   parameter int XLEN    = 32,
   parameter int MAX_LEN = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   fp32_mac_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);

   localparam logic [1:0] ST_ACC   = 2'd0;
   localparam logic [1:0] ST_ALIGN = 2'd1;
   localparam logic [1:0] ST_NORM  = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   logic [1:0]       state_reg;
   logic [XLEN-1:0]  acc_reg;
   logic [XLEN-1:0]  op_reg;
   logic             last_reg;
   logic [CNT_W-1:0] count_reg;
   logic [24:0]      sum_reg;
   logic [7:0]       exp_reg;
   logic             sign_reg;
   logic             inf_reg;

   logic [23:0] acc_man, op_man, big_man, small_man, small_shift;
   logic [7:0]  big_exp, small_exp, exp_diff;
   logic        big_sign, small_sign, acc_inf, op_inf, acc_is_big;
   logic [24:0] sum_next;
   logic        sign_next, inf_next;

   // Ordering by full magnitude keeps the subtraction non-negative even on equal exponents.
   always_comb begin
      acc_inf    = (acc_reg[30:23] == 8'hFF);
      op_inf     = (op_reg[30:23] == 8'hFF);
      acc_man    = (acc_reg[30:23] == 8'h00) ? 24'h0 : {1'b1, acc_reg[22:0]};
      op_man     = (op_reg[30:23] == 8'h00) ? 24'h0 : {1'b1, op_reg[22:0]};
      acc_is_big = ({acc_reg[30:23], acc_man} >= {op_reg[30:23], op_man});
      big_exp    = acc_is_big ? acc_reg[30:23] : op_reg[30:23];
      small_exp  = acc_is_big ? op_reg[30:23]  : acc_reg[30:23];
      big_man    = acc_is_big ? acc_man : op_man;
      small_man  = acc_is_big ? op_man  : acc_man;
      big_sign   = acc_is_big ? acc_reg[31] : op_reg[31];
      small_sign = acc_is_big ? op_reg[31]  : acc_reg[31];
      exp_diff   = big_exp - small_exp;
      small_shift = (exp_diff >= 8'd25) ? 24'h0 : (small_man >> exp_diff);
      if (big_sign == small_sign) begin
         sum_next = {1'b0, big_man} + {1'b0, small_shift};
      end else begin
         sum_next = {1'b0, big_man} - {1'b0, small_shift};
      end
      inf_next  = acc_inf | op_inf;
      sign_next = acc_inf ? acc_reg[31] : (op_inf ? op_reg[31] : big_sign);
   end

   logic [23:0] zero_above;
   logic [4:0]  lzc;
   logic [23:0] norm_man;
   logic [XLEN-1:0] norm_next;

   generate
      for (genvar gi = 0; gi < 24; gi++) begin : g_lzc
         assign zero_above[gi] = ~|sum_reg[23:gi];
      end
   endgenerate

   always_comb begin
      lzc = 5'd0;
      for (int i = 0; i < 24; i++) begin
         lzc = lzc + {4'd0, zero_above[i]};
      end
      norm_man = sum_reg[23:0] << lzc;
      if (inf_reg) begin
         norm_next = {sign_reg, 8'hFF, 23'h0};
      end else if (sum_reg[24]) begin
         if (exp_reg >= 8'hFE) begin
            norm_next = {sign_reg, 8'hFF, 23'h0};
         end else begin
            norm_next = {sign_reg, exp_reg + 8'd1, sum_reg[23:1]};
         end
      end else if ((sum_reg[23:0] == 24'h0) || (exp_reg <= {3'b000, lzc})) begin
         norm_next = '0;
      end else begin
         norm_next = {sign_reg, exp_reg - {3'b000, lzc}, norm_man[22:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_ACC;
         acc_reg   <= '0;
         op_reg    <= '0;
         last_reg  <= 1'b0;
         count_reg <= '0;
         sum_reg   <= '0;
         exp_reg   <= '0;
         sign_reg  <= 1'b0;
         inf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_ACC: begin
               if (bus.in_valid) begin
                  op_reg    <= bus.in_data;
                  last_reg  <= bus.in_last;
                  count_reg <= count_reg + CNT_W'(1);
                  state_reg <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               sum_reg   <= sum_next;
               exp_reg   <= big_exp;
               sign_reg  <= sign_next;
               inf_reg   <= inf_next;
               state_reg <= ST_NORM;
            end
            ST_NORM: begin
               acc_reg   <= norm_next;
               state_reg <= (last_reg || (count_reg == CNT_W'(MAX_LEN))) ? ST_OUT : ST_ACC;
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  acc_reg   <= '0;
                  count_reg <= '0;
                  state_reg <= ST_ACC;
               end
            end
            default: state_reg <= ST_ACC;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == ST_ACC);
   assign bus.out_valid = (state_reg == ST_OUT);
   assign bus.out_count = count_reg;
`ifdef ACC_RELU_EN
   assign bus.out_data  = acc_reg[XLEN-1] ? '0 : acc_reg;
`else
   assign bus.out_data  = acc_reg;
`endif
endmodule
